switch_debouncer: RTL and testbench

//   Input-side conditioning for the board slide switches. Synchronises each raw

---
 rtl/switch_debouncer.sv | 111 +++++++++++
 tb/tb_switch_debouncer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises, debounces and edge-detects WIDTH raw switch
// inputs. Each bit has its own synchroniser chain, mismatch counter and stable
// register; rise/fall are one-cycle registered pulses aligned with the first
// cycle the new stable level is visible.
// Optional feature macro: SWITCH_STICKY_EN adds sticky_clr / sticky, a per-bit
// change flag that latches on any rise or fall until cleared.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] switch,
`ifdef SWITCH_STICKY_EN
    input  logic             sticky_clr,
    output logic [WIDTH-1:0] sticky,
`endif
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              changed_q, changed_d;
    logic [WIDTH-1:0]                  sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Shift the raw switch bits through the synchroniser chain.
    always_comb begin
        sync_d[0] = switch;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Per-bit debounce: count consecutive disagreeing cycles, flip on the Nth.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_out[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = ~stable_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d    = stable_d & ~stable_q;
        fall_d    = ~stable_d & stable_q;
        changed_d = |(rise_d | fall_d);
    end

    // State registers; everything clears asynchronously while rstb is low.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rstb) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign stable  = stable_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

`ifdef SWITCH_STICKY_EN
    logic [WIDTH-1:0] sticky_q, sticky_d;

    // Latch any visible edge pulse; a clear loses to a set on the same bit.
    always_comb begin
        sticky_d = (sticky_clr ? '0 : sticky_q) | rise_q | fall_q;
    end

    // Sticky flag register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Testbench for switch_debouncer (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A reference model predicts each cycle's outputs from the sampled input
// history; a monitor pops those predictions and compares against the DUT.
module tb_switch_debouncer;

    localparam int W = 8;
    localparam int S = 2;
    localparam int N = 4;

    typedef struct packed {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         changed;
        logic [W-1:0] sticky;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstb;
    logic [W-1:0] switch;
    logic [W-1:0] stable, rise, fall;
    logic         changed;
    logic         sticky_clr;
    logic [W-1:0] sticky;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .switch    (switch),
`ifdef SWITCH_STICKY_EN
        .sticky_clr(sticky_clr),
        .sticky    (sticky),
`endif
        .stable    (stable),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed)
    );

`ifndef SWITCH_STICKY_EN
    assign sticky = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a bit's level is accepted once the last N synchronised
    // samples all disagree with the current level; edges follow from that.
    initial begin : model
        logic [W-1:0] m_x[$];
        logic [W-1:0] m_so[$];
        logic [W-1:0] m_stable, new_stable, so;
        logic [W-1:0] m_rise, m_fall, m_sticky;
        bit           all_diff;
        exp_t         e;
        m_stable = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
        forever begin
            @(posedge clk);
            if (rstb !== 1'b1) begin
                m_x.delete();
                m_so.delete();
                m_stable = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
                e = '0;
            end else begin
                m_x.push_back(switch);
                so = (m_x.size() > S) ? m_x[m_x.size()-1-S] : '0;
                m_so.push_back(so);
                if (m_x.size() > 32) void'(m_x.pop_front());
                if (m_so.size() > 32) void'(m_so.pop_front());
                new_stable = m_stable;
                for (int i = 0; i < W; i++) begin
                    all_diff = (m_so.size() >= N);
                    for (int j = 0; j < N && all_diff; j++) begin
                        if (m_so[m_so.size()-1-j][i] == m_stable[i]) all_diff = 0;
                    end
                    if (all_diff) new_stable[i] = ~m_stable[i];
                end
                m_sticky = (sticky_clr ? '0 : m_sticky) | m_rise | m_fall;
                m_rise   = new_stable & ~m_stable;
                m_fall   = m_stable & ~new_stable;
                m_stable = new_stable;
                e.stable  = m_stable;
                e.rise    = m_rise;
                e.fall    = m_fall;
                e.changed = |(m_rise | m_fall);
`ifdef SWITCH_STICKY_EN
                e.sticky  = m_sticky;
`else
                e.sticky  = '0;
`endif
            end
            sb_q.push_back(e);
        end
    end

    // Monitor: one prediction per clock edge, compared just after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_stable",  32'(stable),  32'(e.stable));
                check("sb_rise",    32'(rise),    32'(e.rise));
                check("sb_fall",    32'(fall),    32'(e.fall));
                check("sb_changed", 32'(changed), 32'(e.changed));
`ifdef SWITCH_STICKY_EN
                check("sb_sticky",  32'(sticky),  32'(e.sticky));
`endif
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [W-1:0] v);
        @(negedge clk);
        switch = v;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [W-1:0] base;
        int           hold;
        rstb = 1'b0;
        switch = '0;
        sticky_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stable", 32'(stable), 32'd0);
        check("reset_changed", 32'(changed), 32'd0);

        // 1: release reset with switch=01; accepted after edge 6
        @(negedge clk);
        rstb = 1'b1;
        switch = 8'h01;
        edges(5);
        check("t1_stable_e5", 32'(stable), 32'h00);
        edges(1);
        check("t1_stable_e6", 32'(stable), 32'h01);
        check("t1_rise_e6", 32'(rise), 32'h01);
        check("t1_changed_e6", 32'(changed), 32'd1);
        edges(1);
        check("t1_rise_e7", 32'(rise), 32'h00);

        // 2: 3-cycle bounce is rejected
        drive(8'h00);
        edges(3);
        drive(8'h01);
        edges(6);
        check("t2_stable", 32'(stable), 32'h01);

        // 3: held drop is accepted after 6 edges
        drive(8'h00);
        edges(5);
        check("t3_stable_e5", 32'(stable), 32'h01);
        edges(1);
        check("t3_stable_e6", 32'(stable), 32'h00);
        check("t3_fall_e6", 32'(fall), 32'h01);
        edges(1);
        check("t3_fall_e7", 32'(fall), 32'h00);

        // 4: staggered steps give staggered rise pulses
        drive(8'hF0);
        edges(2);
        drive(8'hFF);
        edges(4);
        check("t4_rise_e6", 32'(rise), 32'hF0);
        edges(2);
        check("t4_rise_e8", 32'(rise), 32'h0F);
        check("t4_stable_e8", 32'(stable), 32'hFF);

        // 5: reset mid-count clears outputs at once; rise[7] 6 edges after release
        drive(8'h80);
        edges(4);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check("t5_async_stable", 32'(stable), 32'h00);
        check("t5_async_pulses", 32'({rise, fall, 7'd0, changed}), 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        edges(5);
        check("t5_stable_e5", 32'(stable), 32'h00);
        edges(1);
        check("t5_rise_e6", 32'(rise), 32'h80);
        check("t5_stable_e6", 32'(stable), 32'h80);

        // Randomised phase: held levels with random bounce and occasional reset
        for (int it = 0; it < 60; it++) begin
            base = W'($urandom);
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                rstb = 1'b0;
                @(negedge clk);
                rstb = 1'b1;
            end
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                switch = ($urandom_range(0, 3) == 0) ? (base ^ (W'($urandom) & W'($urandom))) : base;
                sticky_clr = ($urandom_range(0, 7) == 0);
            end
        end
        @(negedge clk);
        sticky_clr = 1'b0;
        edges(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
